// File: rtl/aes_cbc_ctrl.sv
// aes_cbc_ctrl: CBC-mode sequencer wrapped around an external combinational
// AES-128 encryption core. Plaintext arrives on a valid/ready stream. Each
// block is chained with the IV or the previous ciphertext and driven onto
// the core through registers. After a fixed multicycle settle time the core
// result is captured and presented on a ciphertext valid/ready stream.
module aes_cbc_ctrl #(
    parameter int WAIT_CYCLES = 2,   // core settle time in cycles, 1..15
    parameter int CNT_W       = 16   // width of the accepted-block counter
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [127:0]     key_in,
    input  logic [127:0]     iv,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [127:0]     s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [127:0]     m_data,
    output logic             m_last,
    output logic [127:0]     aes_key,
    output logic [127:0]     aes_data,
    input  logic [127:0]     aes_cdata,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // The wait counter reloads to WAIT_CYCLES-1 so that the capture edge
    // falls exactly WAIT_CYCLES edges after the accepting edge.
    localparam logic [3:0]       WCNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             r_state;
    logic [127:0]       r_key;
    logic [127:0]       r_chain;
    logic [127:0]       r_aes_data;
    logic [127:0]       r_m_data;
    logic               r_m_last;
    logic               r_last;
    logic [CNT_W-1:0]   r_blk_cnt;
    logic [3:0]         r_wcnt;
    logic               r_s_ready;
    logic               r_m_valid;
    logic               r_busy;

    // Handshake/status outputs are kept as dedicated flops, updated in step
    // with every state transition, so they never glitch on state decode.
    assign s_ready  = r_s_ready;
    assign m_valid  = r_m_valid;
    assign busy     = r_busy;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign aes_key  = r_key;
    assign aes_data = r_aes_data;
    assign blk_cnt  = r_blk_cnt;

    // Control FSM and datapath registers: start latch, chaining XOR,
    // multicycle settle countdown and ciphertext output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_key      <= 128'd0;
            r_chain    <= 128'd0;
            r_aes_data <= 128'd0;
            r_m_data   <= 128'd0;
            r_m_last   <= 1'b0;
            r_last     <= 1'b0;
            r_blk_cnt  <= '0;
            r_wcnt     <= 4'd0;
            r_s_ready  <= 1'b0;
            r_m_valid  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // s_valid is deliberately ignored here, even alongside start.
                    if (start) begin
                        r_key     <= key_in;
                        r_chain   <= iv;
                        r_blk_cnt <= '0;
                        r_state   <= ST_ACCEPT;
                        r_s_ready <= 1'b1;
                        r_busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCEPT: begin
                    if (s_valid) begin
                        r_aes_data <= s_data ^ r_chain;
                        r_last     <= s_last;
                        r_blk_cnt  <= r_blk_cnt + CNT_ONE;
                        r_wcnt     <= WCNT_INIT;
                        r_state    <= ST_WAIT;
                        r_s_ready  <= 1'b0;
                    end else begin
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_WAIT: begin
                    // Core inputs are frozen here; the core path settles.
                    if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end else begin
                        r_m_data  <= aes_cdata;
                        r_chain   <= aes_cdata;
                        r_m_last  <= r_last;
                        r_state   <= ST_OUT;
                        r_m_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_m_last) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= ST_ACCEPT;
                            r_s_ready <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_OUT;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b0;
                    r_m_valid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_ctrl.sv
// Scoreboard bench for aes_cbc_ctrl. A table-driven stand-in for the AES
// core answers only the known FIPS-197 / SP800-38A input points; any other
// key/data combination yields an unrelated value, so wrong chaining or a
// corrupted key shows up as a ciphertext mismatch.
module tb_aes_cbc_ctrl;

    localparam int WAIT_CYCLES = 2;
    localparam int CNT_W       = 16;

    localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1_P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T1_C  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C1    = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] C2    = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] KEY_X = 128'hdeadbeef00112233445566778899aabb;
    localparam logic [127:0] IV_X  = 128'h0f0e0d0c0b0a09080706050403020100;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [127:0]     key_in;
    logic [127:0]     iv;
    logic             s_valid;
    logic             s_ready;
    logic [127:0]     s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [127:0]     m_data;
    logic             m_last;
    logic [127:0]     aes_key;
    logic [127:0]     aes_data;
    logic [127:0]     aes_cdata;
    logic             busy;
    logic [CNT_W-1:0] blk_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    logic         prev_mv = 1'b0;
    logic [127:0] hold_data;
    logic         hold_last;
    logic [128:0] exp_q[$];   // {last, data}

    aes_cbc_ctrl #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .iv(iv),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .aes_key(aes_key), .aes_data(aes_data), .aes_cdata(aes_cdata),
        .busy(busy), .blk_cnt(blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the combinational AES core over the known vector points.
    always_comb begin
        aes_cdata = aes_data ^ {aes_key[63:0], aes_key[127:64]} ^ 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
        if (aes_key == KEY && aes_data == T1_P)           aes_cdata = T1_C;
        else if (aes_key == KEY && aes_data == (P1 ^ IV2)) aes_cdata = C1;
        else if (aes_key == KEY && aes_data == (P2 ^ C1))  aes_cdata = C2;
        else                                                aes_cdata = aes_cdata;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency, stability under backpressure, scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mv = 1'b0;
        end else begin
            if (s_valid && s_ready) acc_cyc = cyc;
            if (m_valid) begin
                if (!prev_mv) begin
                    chk("latency", 128'(cyc - acc_cyc), 128'(WAIT_CYCLES + 1));
                    hold_data = m_data;
                    hold_last = m_last;
                end else begin
                    chk("hold_data", m_data, hold_data);
                    chk("hold_last", 128'(m_last), 128'(hold_last));
                end
                chk("s_ready_in_out", 128'(s_ready), 128'd0);
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 128'(m_valid), 128'd0);
                    end else begin
                        logic [128:0] e;
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e[127:0]);
                        chk("m_last", 128'(m_last), 128'(e[128]));
                    end
                end
            end
            prev_mv = m_valid;
        end
    end

    task automatic do_start(input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        key_in = k; iv = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic l, input logic [127:0] c);
        int n;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = l;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("accept_timeout", 128'(s_ready), 128'd1);
        else exp_q.push_back({l, c});
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_queue", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic wait_mvalid();
        int n;
        n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mvalid_timeout", 128'(m_valid), 128'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key_in = 128'd0; iv = 128'd0;
        s_valid = 1'b0; s_data = 128'd0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 128'(s_ready), 128'd0);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_aes_key", aes_key, 128'd0);
        rst_n = 1'b1;

        // T1: single block with zero IV behaves as ECB
        do_start(KEY, 128'd0);
        send(T1_P, 1'b1, T1_C);
        wait_idle();
        chk("t1_blk_cnt", 128'(blk_cnt), 128'd1);

        // T2: two-block CBC
        do_start(KEY, IV2);
        send(P1, 1'b0, C1);
        send(P2, 1'b1, C2);
        wait_idle();
        chk("t2_blk_cnt", 128'(blk_cnt), 128'd2);

        // T3: backpressure on the first ciphertext block
        m_ready = 1'b0;
        do_start(KEY, IV2);
        send(P1, 1'b0, C1);
        wait_mvalid();
        repeat (10) @(negedge clk);
        m_ready = 1'b1;
        send(P2, 1'b1, C2);
        wait_idle();
        chk("t3_blk_cnt", 128'(blk_cnt), 128'd2);

        // T4: start pulsed while busy is ignored
        do_start(KEY, IV2);
        send(P1, 1'b0, C1);
        do_start(KEY_X, IV_X);
        chk("t4_key", aes_key, KEY);
        chk("t4_blk_cnt_mid", 128'(blk_cnt), 128'd1);
        send(P2, 1'b1, C2);
        wait_idle();
        chk("t4_blk_cnt", 128'(blk_cnt), 128'd2);

        // T6: start with simultaneous s_valid in IDLE
        @(negedge clk);
        key_in = KEY; iv = 128'd0; start = 1'b1;
        s_valid = 1'b1; s_data = T1_P; s_last = 1'b1;
        chk("t6_s_ready", 128'(s_ready), 128'd0);
        @(posedge clk);
        #1 start = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("t6_blk_cnt", 128'(blk_cnt), 128'd0);
        chk("t6_accept_state", 128'(s_ready), 128'd1);
        send(T1_P, 1'b1, T1_C);
        wait_idle();

        // T5: reset during WAIT discards the block
        do_start(KEY, 128'd0);
        send(T1_P, 1'b1, T1_C);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_m_valid", 128'(m_valid), 128'd0);
        chk("t5_busy", 128'(busy), 128'd0);
        chk("t5_m_data", m_data, 128'd0);
        chk("t5_aes_data", aes_data, 128'd0);
        chk("t5_aes_key", aes_key, 128'd0);
        chk("t5_blk_cnt", 128'(blk_cnt), 128'd0);
        repeat (3) @(negedge clk);
        chk("t5_m_valid_held", 128'(m_valid), 128'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_output", 128'(m_valid), 128'd0);
        do_start(KEY, 128'd0);
        send(T1_P, 1'b1, T1_C);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
